board_draw_sched: RTL and testbench
===================================

# board_draw_sched

Scheduler that repaints the Tetris playfield by walking the board cell by cell. For each cell it reads the colour from the board store and launches one square-fill operation on the shared square filler at that cell's pixel origin. It waits for the filler's completion before moving on. It sits between the game logic (which requests a repaint) and the square filler feeding the frame-buffer write port.

## Interface
Parameters:
- COLS, 10, board width in cells
- ROWS, 20, board height in cells
- CELL_PITCH, 24, pixel pitch between cell origins (23-px square plus 1-px gap)
- X0, 100, pixel x of cell (row 0, col 0) origin
- Y0, 10, pixel y of cell (row 0, col 0) origin

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  repaint request, sampled in IDLE only
- busy  out  1  high from the cycle after start is accepted until DONE completes
- done  out  1  one-cycle pulse when the last cell's fill completes
- cell_rd  out  1  board-store read strobe
- cell_row  out  5  row address, 0 = top
- cell_col  out  4  column address, 0 = left
- cell_data  in  3  colour; valid the cycle after cell_rd (1-cycle read latency); 0 = empty/background
- sq_start  out  1  one-cycle pulse, drives the filler's start/load input
- sq_refX  out  11  square origin x
- sq_refY  out  11  square origin y
- sq_color  out  3  colour for the pixel writer
- sq_done  in  1  filler completion pulse

## Operation
- States: IDLE, READ, WAIT_RD, ISSUE, WAIT_SQ, DONE.
- IDLE: start=1 → READ. Row/col counters cleared. sq_refX=X0, sq_refY=Y0.
- READ: cell_rd=1 with the current row/col → WAIT_RD.
- WAIT_RD: cell_data registered into sq_color → ISSUE.
- ISSUE: sq_start=1 → WAIT_SQ.
- WAIT_SQ: hold all sq_* outputs stable. On sq_done:
  - last cell (row ROWS-1, col COLS-1) → DONE;
  - otherwise advance the counters and go to READ.
- Advance is row-major:
  - col+1, with sq_refX += CELL_PITCH;
  - at col COLS-1: col=0, row+1, sq_refX=X0, sq_refY += CELL_PITCH.
- Coordinates are computed by accumulation, with no multiplier. All coordinate arithmetic is 11-bit unsigned, wrapping. Default parameters keep the maximum at 316/466, with no overflow.
- DONE: done=1 → IDLE.
- Every cell is painted, including empty cells (colour 0), so stale blocks are erased.
- start outside IDLE is ignored; there is no queuing.
- sq_done outside WAIT_SQ is ignored.
- Reset in any state → IDLE next edge. Reset values: busy, done, cell_rd, sq_start = 0; cell_row, cell_col, sq_color = 0; sq_refX=X0; sq_refY=Y0. A partially painted frame is abandoned.

## Timing
- start sampled high at edge k:
  - cycle k+1 READ, busy=1;
  - cycle k+2 WAIT_RD;
  - cycle k+3 ISSUE, sq_start=1 with sq_refX/sq_refY/sq_color valid.
- sq_done sampled at edge m → cycle m+1 is READ of the next cell, or DONE.
- Per-cell cost: 3 cycles of overhead plus filler latency. Frame = ROWS·COLS·(3+F) + 2 cycles, where F is the number of cycles from sq_start to sq_done.
- sq_refX/sq_refY/sq_color change only on the transition into READ (advance) or when latched in WAIT_RD. They never change while the filler is running.
- busy deasserts the cycle after DONE. A new start may be accepted on that same cycle.

## Structure
- Shared package tetris_draw_pkg: COLS, ROWS, CELL_PITCH, color_t (3-bit typedef), board_draw_state_t enum.
- No sub-module. The square filler and board store are instantiated by the parent; this block only sequences them.

## Test plan
- Full frame, X0=100, Y0=10, mock filler with sq_done 5 cycles after sq_start:
  - exactly 200 sq_start pulses;
  - first at (100,10);
  - cell (0,9) at (316,10);
  - cell (1,0) at (100,34);
  - last at (316,466);
  - one done pulse;
  - frame length 200·8+2 cycles.
- Board pattern colour = (row+col) mod 8 → each sq_color matches, including colour-0 cells being issued.
- start pulsed again during WAIT_SQ of cell 37 → ignored, still 200 fills and one done.
- Spurious sq_done in READ and ISSUE → no advance; coordinates unchanged.
- Reset asserted in WAIT_SQ of cell 55 → next cycle IDLE with busy=0, sq_refX=100, sq_refY=10. A following start repaints from cell (0,0).
- start held high continuously → back-to-back frames, done every 1602 cycles. busy low for exactly one cycle between frames.

Source files
------------

// File: rtl/tetris_draw_pkg.sv
// tetris_draw_pkg: shared playfield geometry, colour type and board-repaint FSM states.
package tetris_draw_pkg;
  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int CELL_PITCH = 24;
  typedef logic [2:0] color_t;
  typedef enum logic [2:0] {IDLE, READ, WAIT_RD, ISSUE, WAIT_SQ, DONE} board_draw_state_t;
endpackage

// File: rtl/board_draw_sched.sv
// board_draw_sched: walks the board row-major, issuing one square fill per cell at its pixel origin.
module board_draw_sched #(
  parameter int COLS = tetris_draw_pkg::COLS,
  parameter int ROWS = tetris_draw_pkg::ROWS,
  parameter int CELL_PITCH = tetris_draw_pkg::CELL_PITCH,
  parameter int X0 = 100,
  parameter int Y0 = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        cell_rd,
  output logic [4:0]  cell_row,
  output logic [3:0]  cell_col,
  input  logic [2:0]  cell_data,
  output logic        sq_start,
  output logic [10:0] sq_refX,
  output logic [10:0] sq_refY,
  output logic [2:0]  sq_color,
  input  logic        sq_done
);
  import tetris_draw_pkg::*;
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
  localparam logic [3:0] COL_LAST = 4'(COLS - 1);
  localparam logic [10:0] PITCH = 11'(CELL_PITCH);
  localparam logic [10:0] X0_C = 11'(X0);
  localparam logic [10:0] Y0_C = 11'(Y0);
  board_draw_state_t state_q, state_d;
  logic [4:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  color_t color_q, color_d;
  logic last_cell;
  assign last_cell = (row_q == ROW_LAST) && (col_q == COL_LAST);
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    x_d = x_q;
    y_d = y_q;
    color_d = color_q;
    case (state_q)
      IDLE: begin
        row_d = '0;
        col_d = '0;
        x_d = X0_C;
        y_d = Y0_C;
        state_d = start ? READ : IDLE;
      end
      READ: state_d = WAIT_RD;
      WAIT_RD: begin
        color_d = cell_data;
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT_SQ;
      WAIT_SQ: if (sq_done) begin
        state_d = last_cell ? DONE : READ;
        // coordinates accumulate rather than multiply; row wrap rewinds x to the left edge
        if (!last_cell) begin
          col_d = (col_q == COL_LAST) ? '0 : col_q + 4'd1;
          row_d = (col_q == COL_LAST) ? row_q + 5'd1 : row_q;
          x_d = (col_q == COL_LAST) ? X0_C : x_q + PITCH;
          y_d = (col_q == COL_LAST) ? y_q + PITCH : y_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      x_q <= X0_C;
      y_q <= Y0_C;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      x_q <= x_d;
      y_q <= y_d;
      color_q <= color_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign cell_rd = state_q == READ;
  assign sq_start = state_q == ISSUE;
  assign cell_row = row_q;
  assign cell_col = col_q;
  assign sq_refX = x_q;
  assign sq_refY = y_q;
  assign sq_color = color_q;
endmodule

// File: tb/tb_board_draw_sched.sv
// tb_board_draw_sched: random-board repaint frames checked against a per-cell geometry model.
module tb_board_draw_sched;
  localparam int NC = 10;
  localparam int NR = 20;
  localparam int NCELL = NC * NR;
  logic clk = 0, reset = 1, start = 0, sq_done = 0;
  logic busy, done, cell_rd, sq_start;
  logic [4:0] cell_row;
  logic [3:0] cell_col;
  logic [2:0] cell_data = 0, sq_color;
  logic [10:0] sq_refX, sq_refY;
  logic [2:0] board [NCELL];
  int n_chk = 0, n_pass = 0, cyc = 0, frame_cyc = 0, n = 0, pend = 0, f_lat = 5, done_cnt = 0;
  int fx [NCELL], fy [NCELL], fc [NCELL];
  int held_x, held_y, held_c;
  bit done_seen = 0, spur = 0;

  board_draw_sched dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .cell_rd(cell_rd), .cell_row(cell_row), .cell_col(cell_col), .cell_data(cell_data),
    .sq_start(sq_start), .sq_refX(sq_refX), .sq_refY(sq_refY), .sq_color(sq_color),
    .sq_done(sq_done)
  );

  always #5 clk = ~clk;

  // board store: one-cycle read latency, junk on the bus when not reading
  always @(posedge clk) begin
    int a;
    a = int'(cell_row) * NC + int'(cell_col);
    cell_data <= (cell_rd && a < NCELL) ? board[a] : 3'($urandom);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (busy) frame_cyc++;
    if (cell_rd) begin
      chk("rd_row", cell_row, n / NC);
      chk("rd_col", cell_col, n % NC);
    end
    if (sq_start) begin
      if (n < NCELL) begin
        chk("fill_x", sq_refX, 100 + 24 * (n % NC));
        chk("fill_y", sq_refY, 10 + 24 * (n / NC));
        chk("fill_color", sq_color, board[n]);
        fx[n] = sq_refX; fy[n] = sq_refY; fc[n] = sq_color;
      end else chk("extra_fill", n, NCELL - 1);
      held_x = sq_refX; held_y = sq_refY; held_c = sq_color;
      n++;
    end
    if (pend > 0) begin
      chk("hold_x", sq_refX, held_x);
      chk("hold_y", sq_refY, held_y);
      chk("hold_color", sq_color, held_c);
    end
    if (done) begin
      chk("fills_at_done", n, NCELL);
      chk("frame_len", frame_cyc, NCELL * (3 + f_lat) + 1);
      done_cnt++;
      done_seen = 1;
      n = 0;
      frame_cyc = 0;
    end
    sq_done = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) sq_done = 1;
    end
    if (sq_start) pend = f_lat;
    if (spur && (cell_rd || sq_start) && $urandom_range(1, 0) == 1) sq_done = 1;
  endtask

  task automatic wait_done(input string nm, input int pulse_at);
    bit pulsed = 0;
    int k = 0;
    done_seen = 0;
    while (!done_seen && k < 12000) begin
      start = (!pulsed && pulse_at >= 0 && n == pulse_at + 1 && pend > 0) ? 1'b1 : start;
      if (start && pulse_at >= 0 && !pulsed && pend > 0) pulsed = 1;
      step();
      if (pulse_at >= 0 && pulsed) start = 0;
      k++;
    end
    if (!done_seen) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic run_frame(input string nm, input int pulse_at);
    start = 1;
    step();
    start = 0;
    wait_done(nm, pulse_at);
    step();
  endtask

  initial begin
    int d0, t1;
    for (int i = 0; i < NCELL; i++) board[i] = 3'((i / NC + i % NC) % 8);
    repeat (3) step();
    reset = 0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_x", sq_refX, 100);
    chk("rst_y", sq_refY, 10);
    chk("rst_outs", {done, cell_rd, sq_start, cell_row, cell_col, sq_color}, 0);
    // pattern frame, fixed filler latency 5: pin the model with literal expectations
    d0 = done_cnt;
    run_frame("frame1", -1);
    chk("f1_dones", done_cnt - d0, 1);
    chk("first_x", fx[0], 100);
    chk("first_y", fy[0], 10);
    chk("first_color", fc[0], 0);
    chk("c09_x", fx[9], 316);
    chk("c09_y", fy[9], 10);
    chk("c10_x", fx[10], 100);
    chk("c10_y", fy[10], 34);
    chk("last_x", fx[199], 316);
    chk("last_y", fy[199], 466);
    chk("last_color", fc[199], 4);
    chk("c08_color", fc[8], 0);
    chk("idle_after", busy, 0);
    // random board, extra start during cell 37's fill
    for (int i = 0; i < NCELL; i++) board[i] = 3'($urandom);
    d0 = done_cnt;
    run_frame("frame2", 37);
    step();
    chk("f2_dones", done_cnt - d0, 1);
    chk("f2_idle", busy, 0);
    // random latency with spurious sq_done in READ/ISSUE
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NCELL; i++) board[i] = 3'($urandom);
      f_lat = $urandom_range(6, 1);
      spur = 1;
      run_frame("spur_frame", -1);
    end
    spur = 0;
    f_lat = 5;
    // reset while cell 55 is being filled
    start = 1;
    step();
    start = 0;
    for (int k = 0; k < 3000 && !(n == 56 && pend > 0); k++) step();
    chk("reached_c55", n, 56);
    reset = 1;
    n = 0; pend = 0; frame_cyc = 0; sq_done = 0;
    step();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_x", sq_refX, 100);
    chk("mid_rst_y", sq_refY, 10);
    chk("mid_rst_outs", {done, cell_rd, sq_start}, 0);
    reset = 0;
    step();
    for (int i = 0; i < NCELL; i++) board[i] = 3'($urandom);
    run_frame("after_rst", -1);
    // start held: back-to-back frames with a single idle cycle between them
    start = 1;
    wait_done("held1", -1);
    t1 = cyc;
    step();
    chk("gap_busy_low", busy, 0);
    step();
    chk("gap_busy_high", busy, 1);
    wait_done("held2", -1);
    chk("done_period", cyc - t1, 1602);
    t1 = cyc;
    wait_done("held3", -1);
    chk("done_period2", cyc - t1, 1602);
    start = 0;
    repeat (4) step();
    chk("held_stop", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
